// File: rtl/alu_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : alu_arbiter
// Purpose  : Round-robin arbiter that lets two requesters (A and B) share one
//            external combinational ALU. An accepted request registers its
//            operands and opcode onto the ALU bus. It waits one execute cycle,
//            or DIV_CYCLES execute cycles for divide/remainder. It then
//            captures the ALU outputs into the owner's result registers and
//            pulses the owner's rsp_valid for one cycle.
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
// Parameters
//   DIV_CYCLES   execute cycles for opcodes 1001 (div) / 1010 (rem), 1..15
// Ports
//   clk          rising-edge clock
//   rst_n        asynchronous active-low reset
//   a_valid      in   requester A has an operation pending
//   a_ready      out  A accepted this cycle (combinational, IDLE only)
//   a_x, a_y     in   A operands (32b)
//   a_op         in   A opcode (4b)
//   a_rsp_valid  out  one-cycle pulse, a_result / a_equal updated
//   a_result     out  A captured result (32b)
//   a_equal      out  A captured equality flag
//   b_*          same set for requester B
//   alu_x, alu_y out  registered operands to the shared ALU
//   alu_s        out  registered opcode to the shared ALU
//   alu_result   in   combinational ALU result
//   alu_equal    in   combinational ALU equality flag
//   busy         out  high while an operation is executing
// ============================================================================
module alu_arbiter #(
  parameter int unsigned DIV_CYCLES = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  // requester A
  input  logic        a_valid,
  output logic        a_ready,
  input  logic [31:0] a_x,
  input  logic [31:0] a_y,
  input  logic [3:0]  a_op,
  output logic        a_rsp_valid,
  output logic [31:0] a_result,
  output logic        a_equal,
  // requester B
  input  logic        b_valid,
  output logic        b_ready,
  input  logic [31:0] b_x,
  input  logic [31:0] b_y,
  input  logic [3:0]  b_op,
  output logic        b_rsp_valid,
  output logic [31:0] b_result,
  output logic        b_equal,
  // shared ALU
  output logic [31:0] alu_x,
  output logic [31:0] alu_y,
  output logic [3:0]  alu_s,
  input  logic [31:0] alu_result,
  input  logic        alu_equal,
  // status
  output logic        busy
);

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_EXEC = 1'b1
  } state_t;

  // Requester identifiers used for owner / last-served bookkeeping
  localparam logic ID_A = 1'b0;
  localparam logic ID_B = 1'b1;

  localparam logic [3:0] OP_DIV   = 4'b1001;
  localparam logic [3:0] OP_REM   = 4'b1010;
  localparam logic [3:0] DIV_LOAD = 4'(DIV_CYCLES - 1);

  // --------------------------------------------------------------------------
  // State
  // --------------------------------------------------------------------------
  state_t      state_q,      state_d;
  logic [3:0]  cnt_q,        cnt_d;
  logic        owner_q,      owner_d;
  logic        last_q,       last_d;
  logic [31:0] alu_x_q,      alu_x_d;
  logic [31:0] alu_y_q,      alu_y_d;
  logic [3:0]  alu_s_q,      alu_s_d;
  logic [31:0] a_result_q,   a_result_d;
  logic        a_equal_q,    a_equal_d;
  logic        a_rsp_q,      a_rsp_d;
  logic [31:0] b_result_q,   b_result_d;
  logic        b_equal_q,    b_equal_d;
  logic        b_rsp_q,      b_rsp_d;

  // --------------------------------------------------------------------------
  // Arbitration
  // --------------------------------------------------------------------------
  logic        grant_b;
  logic        any_valid;
  logic        is_idle;
  logic [31:0] sel_x;
  logic [31:0] sel_y;
  logic [3:0]  sel_op;
  logic        sel_long;
  logic        blank_op;
  logic [31:0] cap_result;
  logic        cap_equal;

  // On a tie the requester that was not served last wins. last_q resets to B,
  // so A wins the first tie after reset.
  always_comb begin
    grant_b = 1'b0;
    if (a_valid && b_valid) begin
      grant_b = (last_q == ID_A);
    end else begin
      grant_b = b_valid;
    end
  end

  assign any_valid = a_valid | b_valid;
  assign is_idle   = (state_q == ST_IDLE);

  assign sel_x    = grant_b ? b_x  : a_x;
  assign sel_y    = grant_b ? b_y  : a_y;
  assign sel_op   = grant_b ? b_op : a_op;
  assign sel_long = (sel_op == OP_DIV) || (sel_op == OP_REM);

  // Opcodes 1100-1111 are unused. They return zero regardless of the ALU.
  assign blank_op   = (alu_s_q[3:2] == 2'b11);
  assign cap_result = blank_op ? 32'h0 : alu_result;
  assign cap_equal  = blank_op ? 1'b0  : alu_equal;

  // --------------------------------------------------------------------------
  // Next-state / datapath
  // --------------------------------------------------------------------------
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    owner_d    = owner_q;
    last_d     = last_q;
    alu_x_d    = alu_x_q;
    alu_y_d    = alu_y_q;
    alu_s_d    = alu_s_q;
    a_result_d = a_result_q;
    a_equal_d  = a_equal_q;
    b_result_d = b_result_q;
    b_equal_d  = b_equal_q;
    a_rsp_d    = 1'b0;
    b_rsp_d    = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (any_valid) begin
          alu_x_d = sel_x;
          alu_y_d = sel_y;
          alu_s_d = sel_op;
          owner_d = grant_b;
          last_d  = grant_b;
          cnt_d   = sel_long ? DIV_LOAD : 4'd0;
          state_d = ST_EXEC;
        end
      end

      ST_EXEC: begin
        if (cnt_q != 4'd0) begin
          cnt_d = cnt_q - 4'd1;
        end else begin
          // Final execute cycle. The ALU has settled on the registered bus.
          if (owner_q == ID_B) begin
            b_result_d = cap_result;
            b_equal_d  = cap_equal;
            b_rsp_d    = 1'b1;
          end else begin
            a_result_d = cap_result;
            a_equal_d  = cap_equal;
            a_rsp_d    = 1'b1;
          end
          state_d = ST_IDLE;
        end
      end

      default: begin
        state_d = ST_IDLE;
        cnt_d   = 4'd0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      cnt_q      <= 4'd0;
      owner_q    <= ID_A;
      last_q     <= ID_B;
      alu_x_q    <= 32'h0;
      alu_y_q    <= 32'h0;
      alu_s_q    <= 4'h0;
      a_result_q <= 32'h0;
      a_equal_q  <= 1'b0;
      a_rsp_q    <= 1'b0;
      b_result_q <= 32'h0;
      b_equal_q  <= 1'b0;
      b_rsp_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      owner_q    <= owner_d;
      last_q     <= last_d;
      alu_x_q    <= alu_x_d;
      alu_y_q    <= alu_y_d;
      alu_s_q    <= alu_s_d;
      a_result_q <= a_result_d;
      a_equal_q  <= a_equal_d;
      a_rsp_q    <= a_rsp_d;
      b_result_q <= b_result_d;
      b_equal_q  <= b_equal_d;
      b_rsp_q    <= b_rsp_d;
    end
  end

  // --------------------------------------------------------------------------
  // Outputs
  // --------------------------------------------------------------------------
  // Ready is gated by rst_n so that both readys drop as soon as reset
  // asserts, even when a request is still held.
  assign a_ready = rst_n & is_idle & a_valid & ~grant_b;
  assign b_ready = rst_n & is_idle & b_valid &  grant_b;

  assign a_rsp_valid = a_rsp_q;
  assign a_result    = a_result_q;
  assign a_equal     = a_equal_q;
  assign b_rsp_valid = b_rsp_q;
  assign b_result    = b_result_q;
  assign b_equal     = b_equal_q;
  assign alu_x       = alu_x_q;
  assign alu_y       = alu_y_q;
  assign alu_s       = alu_s_q;
  assign busy        = (state_q == ST_EXEC);

endmodule
`default_nettype wire

// File: tb/tb_alu_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_alu_arbiter
// Purpose  : Directed self-checking bench for alu_arbiter. It includes a
//            small behavioural ALU on the shared bus.
// Revision : 1.0 - initial release
// ============================================================================
module tb_alu_arbiter;

  logic        clk;
  logic        rst_n;
  logic        a_valid, b_valid;
  logic        a_ready, b_ready;
  logic [31:0] a_x, a_y, b_x, b_y;
  logic [3:0]  a_op, b_op;
  logic        a_rsp_valid, b_rsp_valid;
  logic [31:0] a_result, b_result;
  logic        a_equal, b_equal;
  logic [31:0] alu_x, alu_y;
  logic [3:0]  alu_s;
  logic [31:0] alu_result;
  logic        alu_equal;
  logic        busy;

  int n_cmp = 0;
  int n_bad = 0;

  alu_arbiter #(.DIV_CYCLES(4)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .a_valid     (a_valid),
    .a_ready     (a_ready),
    .a_x         (a_x),
    .a_y         (a_y),
    .a_op        (a_op),
    .a_rsp_valid (a_rsp_valid),
    .a_result    (a_result),
    .a_equal     (a_equal),
    .b_valid     (b_valid),
    .b_ready     (b_ready),
    .b_x         (b_x),
    .b_y         (b_y),
    .b_op        (b_op),
    .b_rsp_valid (b_rsp_valid),
    .b_result    (b_result),
    .b_equal     (b_equal),
    .alu_x       (alu_x),
    .alu_y       (alu_y),
    .alu_s       (alu_s),
    .alu_result  (alu_result),
    .alu_equal   (alu_equal),
    .busy        (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Shared ALU. Unlisted opcodes return a marker value so that the forced
  // zero for 11xx opcodes is visible.
  always_comb begin
    alu_result = 32'hDEAD_BEEF;
    case (alu_s)
      4'b0010: alu_result = alu_x + alu_y;
      4'b0011: alu_result = alu_x & alu_y;
      4'b1011: alu_result = alu_x - alu_y;
      4'b1001: alu_result = (alu_y != 0) ? alu_x / alu_y : 32'hFFFF_FFFF;
      4'b1010: alu_result = (alu_y != 0) ? alu_x % alu_y : alu_x;
      default: alu_result = 32'hDEAD_BEEF;
    endcase
  end
  assign alu_equal = (alu_x == alu_y);

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  initial begin
    rst_n   = 1'b0;
    a_valid = 1'b1;   // held during reset: ready must stay low
    b_valid = 1'b0;
    a_x = 0; a_y = 0; a_op = 0;
    b_x = 0; b_y = 0; b_op = 0;

    // ---------------- reset state ----------------
    repeat (2) @(negedge clk);
    #1;
    chk("rst_a_ready", a_ready, 0);
    chk("rst_busy",    busy,    0);
    chk("rst_alu_x",   alu_x,   0);
    chk("rst_alu_s",   alu_s,   0);
    chk("rst_a_res",   a_result, 0);
    chk("rst_a_rsp",   a_rsp_valid, 0);
    a_valid = 1'b0;
    rst_n   = 1'b1;

    // ---------------- A add 7+5 ----------------
    @(negedge clk);
    a_valid = 1; a_x = 7; a_y = 5; a_op = 4'b0010;
    #1;
    chk("add_a_ready", a_ready, 1);
    chk("add_b_ready", b_ready, 0);
    @(negedge clk);                       // T+1
    a_valid = 0;
    #1;
    chk("add_busy",  busy,  1);
    chk("add_alu_x", alu_x, 7);
    chk("add_alu_s", alu_s, 4'b0010);
    chk("add_rsp_early", a_rsp_valid, 0);
    @(negedge clk); #1;                   // T+2
    chk("add_a_rsp", a_rsp_valid, 1);
    chk("add_a_res", a_result, 12);
    chk("add_a_eq",  a_equal, 0);
    chk("add_b_rsp", b_rsp_valid, 0);
    chk("add_idle",  busy, 0);
    @(negedge clk); #1;
    chk("add_pulse_end", a_rsp_valid, 0);
    chk("add_res_hold",  a_result, 12);
    chk("alu_x_hold",    alu_x, 7);

    // ---------------- tie after reset ----------------
    @(negedge clk);
    rst_n = 0;
    #1;
    chk("rst2_a_res", a_result, 0);
    @(negedge clk);
    rst_n = 1;
    a_valid = 1; a_x = 9; a_y = 9; a_op = 4'b1011;
    b_valid = 1; b_x = 32'hF0F0F0F0; b_y = 32'h0FF00FF0; b_op = 4'b0011;
    #1;
    chk("tie_a_ready", a_ready, 1);
    chk("tie_b_ready", b_ready, 0);
    @(negedge clk);
    a_valid = 0;
    #1;
    chk("tie_b_wait", b_ready, 0);
    @(negedge clk); #1;
    chk("tie_a_rsp", a_rsp_valid, 1);
    chk("tie_a_res", a_result, 0);
    chk("tie_a_eq",  a_equal, 1);
    chk("tie_b_ready_rsp", b_ready, 1);
    @(negedge clk);
    b_valid = 0;
    #1;
    chk("tie_b_busy", busy, 1);
    chk("tie_alu_s",  alu_s, 4'b0011);
    chk("tie_a_rsp_end", a_rsp_valid, 0);
    @(negedge clk); #1;
    chk("tie_b_rsp", b_rsp_valid, 1);
    chk("tie_b_res", b_result, 32'h00F000F0);
    chk("tie_b_eq",  b_equal, 0);
    chk("tie_a_hold", a_result, 0);
    chk("tie_aeq_hold", a_equal, 1);
    chk("tie_one_rsp", a_rsp_valid, 0);

    // ---------------- B divide 100/7 ----------------
    @(negedge clk);
    b_valid = 1; b_x = 100; b_y = 7; b_op = 4'b1001;
    #1;
    chk("div_b_ready", b_ready, 1);
    for (int k = 1; k <= 4; k++) begin
      @(negedge clk);
      b_valid = 0;
      #1;
      chk("div_busy", busy, 1);
      chk("div_no_rsp", b_rsp_valid, 0);
    end
    @(negedge clk); #1;                   // T+5
    chk("div_b_rsp", b_rsp_valid, 1);
    chk("div_b_res", b_result, 14);
    chk("div_idle",  busy, 0);

    // ---------------- A remainder 100%7 ----------------
    @(negedge clk);
    a_valid = 1; a_x = 100; a_y = 7; a_op = 4'b1010;
    #1;
    chk("rem_a_ready", a_ready, 1);
    repeat (4) @(negedge clk);
    a_valid = 0;
    #1;
    chk("rem_no_rsp", a_rsp_valid, 0);
    @(negedge clk); #1;
    chk("rem_a_rsp", a_rsp_valid, 1);
    chk("rem_a_res", a_result, 2);

    // ---------------- A unused opcode 1111 ----------------
    @(negedge clk);
    a_valid = 1; a_x = 3; a_y = 3; a_op = 4'b1111;
    #1;
    chk("nop_a_ready", a_ready, 1);
    @(negedge clk);
    a_valid = 0;
    @(negedge clk); #1;
    chk("nop_a_rsp", a_rsp_valid, 1);
    chk("nop_a_res", a_result, 0);
    chk("nop_a_eq",  a_equal, 0);

    // ---------------- round-robin, 6 ops ----------------
    @(negedge clk);
    rst_n = 0;
    @(negedge clk);
    rst_n = 1;
    a_valid = 1; a_x = 1; a_y = 1; a_op = 4'b0010;
    b_valid = 1; b_x = 2; b_y = 3; b_op = 4'b0010;
    #1;
    chk("rr_first_a", a_ready, 1);
    chk("rr_first_b", b_ready, 0);
    for (int i = 0; i < 6; i++) begin
      @(negedge clk); #1;
      chk("rr_busy",  busy, 1);
      chk("rr_nordy", {a_ready, b_ready}, 2'b00);
      @(negedge clk); #1;
      if (i % 2 == 0) begin
        chk("rr_rsp_a", {a_rsp_valid, b_rsp_valid}, 2'b10);
        chk("rr_res_a", a_result, 2);
      end else begin
        chk("rr_rsp_b", {a_rsp_valid, b_rsp_valid}, 2'b01);
        chk("rr_res_b", b_result, 5);
      end
      if (i < 5) begin
        chk("rr_next", {a_ready, b_ready}, (i % 2 == 0) ? 2'b01 : 2'b10);
      end
    end
    a_valid = 0; b_valid = 0;

    // ---------------- reset during divide ----------------
    @(negedge clk);
    a_valid = 1; a_x = 50; a_y = 5; a_op = 4'b1001;
    #1;
    chk("abort_a_ready", a_ready, 1);
    @(negedge clk); #1;                   // T+1, request still held
    chk("abort_busy", busy, 1);
    @(negedge clk);                       // T+2
    rst_n = 0;
    #1;
    chk("abort_busy0",  busy, 0);
    chk("abort_ready0", a_ready, 0);
    chk("abort_alu_x",  alu_x, 0);
    chk("abort_alu_s",  alu_s, 0);
    chk("abort_a_res",  a_result, 0);
    chk("abort_b_res",  b_result, 0);
    repeat (3) @(negedge clk);            // spans where T+5 would have been
    #1;
    chk("abort_no_rsp", a_rsp_valid, 0);
    rst_n = 1;
    #1;
    chk("rearb_a_ready", a_ready, 1);
    repeat (4) @(negedge clk);
    a_valid = 0;
    #1;
    chk("rearb_busy", busy, 1);
    @(negedge clk); #1;
    chk("rearb_a_rsp", a_rsp_valid, 1);
    chk("rearb_a_res", a_result, 10);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
